// File: rtl/linebuffer_window.sv
// Raster pixel stream -> WIN_H x WIN_W sliding window, flattened with a zeroed bias slot 0.
// Define LB_STALL_EN to hold each window until win_ready; otherwise win_valid is a one-cycle pulse.
module linebuffer_window #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int WIN_W = 10,
  parameter int WIN_H = 8,
  parameter int PIX_W = 7
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               pix_valid,
  input  logic [PIX_W-1:0]                   pix_in,
  input  logic                               sof,
  output logic                               pix_ready,
  output logic                               win_valid,
  input  logic                               win_ready,
  output logic [(WIN_W*WIN_H+1)*PIX_W-1:0]   window_flat
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_WIN0 = CW'(WIN_W - 1);
  localparam logic [RW-1:0] ROW_WIN0 = RW'(WIN_H - 1);

  logic [CW-1:0]    col_q, col_d, col_cur;
  logic [RW-1:0]    row_q, row_d, row_cur;
  logic             win_valid_q, win_valid_d;
  logic [PIX_W-1:0] win_q [WIN_H][WIN_W];
  logic [PIX_W-1:0] win_d [WIN_H][WIN_W];
  logic [PIX_W-1:0] lb_mem [WIN_H-1][IMG_W];
  logic [PIX_W-1:0] lb_rd [WIN_H-1];
  logic             accept;
  logic             at_win;

`ifdef LB_STALL_EN
  assign pix_ready = !(win_valid_q && !win_ready);
`else
  logic unused_win_ready;
  assign unused_win_ready = win_ready;
  assign pix_ready = 1'b1;
`endif

  // sof relocates the current pixel to (0,0), so it addresses the line buffers too.
  always_comb begin
    accept  = pix_valid && pix_ready;
    col_cur = sof ? '0 : col_q;
    row_cur = sof ? '0 : row_q;
    at_win  = (row_cur >= ROW_WIN0) && (col_cur >= COL_WIN0);
    for (int l = 0; l < WIN_H-1; l++) begin
      lb_rd[l] = lb_mem[l][col_cur];
    end
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    win_d = win_q;
`ifdef LB_STALL_EN
    win_valid_d = win_valid_q && !win_ready;
`else
    win_valid_d = 1'b0;
`endif
    if (accept) begin
      win_valid_d = at_win;
      if (col_cur == COL_LAST) begin
        col_d = '0;
        row_d = (row_cur == ROW_LAST) ? '0 : row_cur + RW'(1);
      end else begin
        col_d = col_cur + CW'(1);
        row_d = row_cur;
      end
      for (int r = 0; r < WIN_H; r++) begin
        for (int c = 0; c < WIN_W-1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
      end
      // lb_rd[l] is the pixel l+1 rows above; the top window row is the oldest.
      for (int r = 0; r < WIN_H-1; r++) begin
        win_d[r][WIN_W-1] = lb_rd[WIN_H-2-r];
      end
      win_d[WIN_H-1][WIN_W-1] = pix_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      for (int r = 0; r < WIN_H; r++) begin
        for (int c = 0; c < WIN_W; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      win_q       <= win_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb_mem[0][col_cur] <= pix_in;
      for (int l = 1; l < WIN_H-1; l++) begin
        lb_mem[l][col_cur] <= lb_mem[l-1][col_cur];
      end
    end
  end

  always_comb begin
    window_flat = '0;
    for (int r = 0; r < WIN_H; r++) begin
      for (int c = 0; c < WIN_W; c++) begin
        window_flat[(1 + r*WIN_W + c)*PIX_W +: PIX_W] = win_q[r][c];
      end
    end
  end

  assign win_valid = win_valid_q;

endmodule

// File: tb/tb_linebuffer_window.sv
// Randomized bench for linebuffer_window against a frame-array reference model.
module tb_linebuffer_window;
  localparam int IW = 16;
  localparam int IH = 12;
  localparam int WW = 10;
  localparam int WH = 8;
  localparam int PW = 7;
  localparam int FW = (WW*WH+1)*PW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pix_valid = 1'b0;
  logic [PW-1:0] pix_in = '0;
  logic          sof = 1'b0;
  logic          pix_ready;
  logic          win_valid;
  logic          win_ready = 1'b1;
  logic [FW-1:0] window_flat;

  always #5 clk = ~clk;

  linebuffer_window #(.IMG_W(IW), .IMG_H(IH), .WIN_W(WW), .WIN_H(WH), .PIX_W(PW)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_in(pix_in), .sof(sof),
    .pix_ready(pix_ready), .win_valid(win_valid), .win_ready(win_ready),
    .window_flat(window_flat)
  );

  int total = 0;
  int bad = 0;

  // Reference model: the frame so far, a linear position index, and the expected window.
  logic [PW-1:0] img [IH][IW];
  int            k;
  bit            exp_vld;
  bit            known;
  logic [FW-1:0] exp_win;
  int            nwin, dut_wins, first_idx;
  logic [FW-1:0] first_flat;
  bit            wr_rand_en = 1'b0;

  task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic bit stall_mode();
`ifdef LB_STALL_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_ready(input bit wr);
    return stall_mode() ? !(exp_vld && !wr) : 1'b1;
  endfunction

  function automatic logic [PW-1:0] pval(input int r, input int c);
    return PW'((r*IW + c) % 128);
  endfunction

  function automatic logic [PW-1:0] slot(input logic [FW-1:0] f, input int s);
    return f[s*PW +: PW];
  endfunction

  task automatic model_reset();
    k = 0;
    exp_vld = 1'b0;
    exp_win = '0;
    known = 1'b1;
  endtask

  task automatic cyc(input bit pv, input logic [PW-1:0] px, input bit sf, input bit wr, output bit acc);
    int r, c;
    pix_valid = pv;
    pix_in    = px;
    sof       = sf;
    win_ready = wr;
    acc = pv && exp_ready(wr) && !rst;
    @(posedge clk);
    if (acc) begin
      if (sf) k = 0;
      r = k / IW;
      c = k % IW;
      img[r][c] = px;
      if (r >= WH-1 && c >= WW-1) begin
        exp_vld = 1'b1;
        known   = 1'b1;
        exp_win = '0;
        for (int rr = 0; rr < WH; rr++)
          for (int cc = 0; cc < WW; cc++)
            exp_win[(1 + rr*WW + cc)*PW +: PW] = img[r-WH+1+rr][c-WW+1+cc];
        nwin++;
      end else begin
        exp_vld = 1'b0;
        known   = 1'b0;
      end
      k = (k + 1) % (IW*IH);
    end else if (stall_mode()) begin
      exp_vld = exp_vld && !wr;
    end else begin
      exp_vld = 1'b0;
    end
    #1;
  endtask

  function automatic bit wr_pick();
    return wr_rand_en ? 1'($urandom % 2) : 1'b1;
  endfunction

  task automatic push(input logic [PW-1:0] px, input bit sf, input int gap);
    bit acc;
    int tries;
    for (int g = 0; g < gap; g++) cyc(1'b0, PW'($urandom), 1'b0, wr_pick(), acc);
    tries = 0;
    do begin
      cyc(1'b1, px, sf, wr_pick(), acc);
      tries++;
    end while (!acc && tries < 40);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL push_timeout: pixel not accepted within %0d cycles", tries);
    end else if (win_valid) begin
      dut_wins++;
    end
  endtask

  task automatic frame(input int gapmax, input bit rnd);
    logic [PW-1:0] px;
    dut_wins = 0;
    nwin = 0;
    first_idx = -1;
    for (int i = 0; i < IW*IH; i++) begin
      px = rnd ? PW'($urandom) : pval(i / IW, i % IW);
      push(px, i == 0, gapmax > 0 ? int'($urandom_range(0, gapmax)) : 0);
      if (dut_wins == 1 && first_idx < 0) begin
        first_idx  = i;
        first_flat = window_flat;
      end
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("win_valid", win_valid, exp_vld);
    chk("pix_ready", pix_ready, exp_ready(win_ready));
    if (known) chk("window_flat", window_flat, exp_win);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit acc;
    int n;
    model_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b1, acc);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_pix_ready", pix_ready, 1);
    chk("rst_window_flat", window_flat, 0);
    rst = 1'b0;

    // Gap-free frame: first window after pixel (7,9), 35 windows in total.
    frame(0, 1'b0);
    chk("t1_first_idx", first_idx, 121);
    chk("t1_slot0", slot(first_flat, 0), 0);
    chk("t1_slot1", slot(first_flat, 1), 0);
    chk("t1_slot10", slot(first_flat, 10), 9);
    chk("t1_slot71", slot(first_flat, 71), 112);
    chk("t1_slot80", slot(first_flat, 80), 121);
    chk("t2_dut_wins", dut_wins, 35);
    chk("t2_model_wins", nwin, 35);

    // Random gaps and random win_ready.
    wr_rand_en = 1'b1;
    frame(3, 1'b0);
    chk("t3_dut_wins", dut_wins, 35);
    frame(3, 1'b1);
    chk("t3r_dut_wins", dut_wins, 35);
    wr_rand_en = 1'b0;

    // Reset mid-frame at pixel (9,3), then restart with sof.
    for (int i = 0; i < 9*IW + 3; i++) push(pval(i / IW, i % IW), i == 0, 0);
    rst = 1'b1;
    model_reset();
    cyc(1'b0, '0, 1'b0, 1'b1, acc);
    cyc(1'b0, '0, 1'b0, 1'b1, acc);
    rst = 1'b0;
    frame(1, 1'b0);
    chk("t4_first_idx", first_idx, 121);
    chk("t4_slot80", slot(first_flat, 80), 121);
    chk("t4_dut_wins", dut_wins, 35);

    // sof mid-frame at pixel (4,5): first window after the 122nd pixel from sof.
    for (int i = 0; i < 4*IW + 5; i++) push(pval(i / IW, i % IW), i == 0, 0);
    dut_wins = 0;
    n = 0;
    while (dut_wins == 0 && n < 200) begin
      push(pval(n / IW, n % IW), n == 0, 0);
      n++;
    end
    chk("t5_pixels_to_window", n, 122);

`ifdef LB_STALL_EN
    // Hold the first window for 5 cycles, then release.
    frame(0, 1'b0);
    for (int i = 0; i < 122; i++) push(pval(i / IW, i % IW), i == 0, 0);
    for (int s = 0; s < 5; s++) begin
      cyc(1'b1, pval(7, 10), 1'b0, 1'b0, acc);
      chk("t6_pix_ready_low", pix_ready, 0);
      chk("t6_slot80_held", slot(window_flat, 80), 121);
    end
    push(pval(7, 10), 1'b0, 0);
    chk("t6_win2_valid", win_valid, 1);
    chk("t6_win2_slot1", slot(window_flat, 1), 1);
    chk("t6_win2_slot10", slot(window_flat, 10), 10);
    chk("t6_win2_slot80", slot(window_flat, 80), 122);
`else
    // win_ready low must not block the stream.
    frame(0, 1'b0);
    for (int i = 0; i < 122; i++) push(pval(i / IW, i % IW), i == 0, 0);
    cyc(1'b1, pval(7, 10), 1'b0, 1'b0, acc);
    chk("t6_ready_ignored", pix_ready, 1);
    chk("t6_win2_slot1", slot(window_flat, 1), 1);
    chk("t6_win2_slot80", slot(window_flat, 80), 122);
`endif

    cyc(1'b0, '0, 1'b0, 1'b1, acc);
    cyc(1'b0, '0, 1'b0, 1'b1, acc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
